uart_rx_controller: RTL
=======================

Name: uart_rx_controller

Overview:
- Sequences one UartRx instance: owns its configuration (divider, parity) and drains each received byte via the ready_o/clear_ready_i handshake into a small FIFO.
- Presents received bytes to the consumer as a valid/ready stream.
- Flags overrun when the FIFO is full.
- Sits between the UartRx receiver and the host-side bus/CPU logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_DIVIDER, 16'd2, clock_divider_o value after reset.
- TIMEOUT_CYCLES, 64, idle clocks before timeout_o asserts (only with the optional feature).

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  1 = drain receiver; 0 = idle, config writable.
- cfg_write_i  in  1  config write strobe.
- cfg_divider_i  in  16  new clock divider.
- cfg_parity_bit_i  in  1  new parity-enable.
- cfg_parity_even_i  in  1  new parity-even select.
- clock_divider_o  out  16  to UartRx clock_divider_i.
- parity_bit_o  out  1  to UartRx parity_bit_i.
- parity_even_o  out  1  to UartRx parity_even_i.
- rx_data_i  in  8  from UartRx data_o.
- rx_ready_i  in  1  from UartRx ready_o.
- rx_clear_ready_o  out  1  to UartRx clear_ready_i.
- data_o  out  8  FIFO head byte.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts head byte.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overrun_o  out  1  sticky; a byte was dropped.
- overrun_clear_i  in  1  clears overrun_o.
- timeout_o  out  1  idle timeout (tied 0 without the optional feature).

Behaviour:
- Reset (reset_i=0, async):
  - clock_divider_o=RESET_DIVIDER; parity_bit_o=0; parity_even_o=0.
  - rx_clear_ready_o=0; valid_o=0; level_o=0; overrun_o=0; timeout_o=0.
  - FIFO pointers 0; FSM=IDLE.
- Config:
  - cfg_write_i sampled only when enable_i=0 and FSM=IDLE; it updates all three config outputs next edge.
  - Writes while enable_i=1 are ignored; config outputs are unchanged.
- FSM (one-hot or encoded, 3 states):
  - IDLE: if enable_i & rx_ready_i:
    - FIFO not full (after the same-cycle pop) -> push rx_data_i.
    - FIFO full -> drop the byte and set overrun_o.
    - Either way, go to CLEAR.
  - CLEAR: rx_clear_ready_o=1 for exactly this one cycle -> WAIT_LOW.
  - WAIT_LOW: rx_clear_ready_o=0; stay while rx_ready_i=1; go to IDLE when rx_ready_i=0. This guarantees each byte is captured exactly once.
- Latency:
  - Byte visible on data_o/valid_o 1 clock after the IDLE-state edge where rx_ready_i=1 was sampled.
  - rx_clear_ready_o high on that same following cycle.
- FIFO:
  - Pop when valid_o & ready_i. Push and pop in the same cycle are allowed at any level, including full (pop frees a slot first). level_o is unchanged in that case.
  - Pointers wrap modulo DEPTH; level_o ranges 0..DEPTH.
  - data_o is the head entry, registered-array read. data_o is don't-care when valid_o=0.
- Overrun:
  - Set on a drop. Cleared by overrun_clear_i.
  - If set and clear occur in the same cycle, set wins.
- enable_i fall:
  - In CLEAR/WAIT_LOW, the FSM completes the handshake first.
  - The FIFO keeps its contents; the consumer may continue popping.

Optional Feature:
- Macro: UART_RX_CTRL_TIMEOUT_EN.
- With the macro:
  - Counter resets on every push or pop. It increments while valid_o=1 and no push occurs, saturating at TIMEOUT_CYCLES.
  - timeout_o=1 when the count equals TIMEOUT_CYCLES. It clears with the counter.
- Without the macro: no counter; timeout_o tied 0.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state typedef (IDLE, CLEAR, WAIT_LOW).
  - Data width constant (8).
  - Divider width constant (16).
- One sub-module, uart_rx_fifo: DEPTH-parameterised sync FIFO with push/pop/full/empty/level ports. It is instantiated once.

Test Plan:
- Reset then divider config: config write with divider=8, parity_bit=1, parity_even=1 while enable_i=0 -> next edge the outputs read 8/1/1.
  - With enable_i=1, a write with divider=3 -> outputs stay 8/1/1.
- Single byte: rx_ready_i rises with rx_data_i=8'h55 -> next cycle valid_o=1, data_o=8'h55, level_o=1, and rx_clear_ready_o pulses for 1 cycle.
  - Holding rx_ready_i=1 for 3 more cycles -> no second push.
- Ordering: receive 8'hAA then 8'h0F with ready_i=0 -> level_o=2. Pop twice -> data_o is 8'hAA then 8'h0F, then valid_o=0.
- Overrun: DEPTH=4; push 5 bytes 8'h01..8'h05 with no pops -> level_o=4 and overrun_o=1.
  - Pops return 8'h01..8'h04.
  - overrun_clear_i -> overrun_o=0.
- Full push+pop: FIFO full with ready_i=1 while 8'h77 arrives -> level_o stays 4, overrun_o stays 0, and 8'h77 is last out.
- Reset mid-operation: assert reset_i in WAIT_LOW with level_o=2 -> all outputs immediately reach reset values; after release, rx_ready_i=1 is re-captured once.
  - With UART_RX_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=64: one byte held -> timeout_o=1 at the 64th idle clock; a pop clears it.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive controller slice:
//   - DATA_W : received byte width
//   - DIV_W  : receiver clock-divider width
//   - rx_state_t : handshake FSM states (IDLE, CLEAR, WAIT_LOW)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    WAIT_LOW = 2'd2
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
// Ports:
//   clk, rst_n      : clock, async active-low reset (pointers/level only)
//   push, wdata     : write strobe and data; caller must not push when full
//                     unless it pops in the same cycle
//   pop             : read strobe; caller must not pop when empty
//   rdata           : head entry (combinational read of the registered array)
//   full, empty     : occupancy flags
//   level           : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  // NOTE: the storage array has no reset; only pointers and level do. Entries
  // are never read before written because valid is derived from the level.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers are AW bits wide, so +1 wraps modulo DEPTH for free.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign level = r_level;
  assign empty = (r_level == '0);
  assign full  = (r_level == LW'(DEPTH));

endmodule : uart_rx_fifo

// File: rtl/uart_rx_controller.sv
// -----------------------------------------------------------------------------
// uart_rx_controller
// Sequences one UartRx receiver: holds its configuration, drains each received
// byte through the ready/clear_ready handshake into a FIFO and presents the
// bytes as a valid/ready stream. Sticky overrun flags a dropped byte.
//
// Optional feature: define UART_RX_CTRL_TIMEOUT_EN to enable the idle timeout
// counter driving timeout_o; otherwise timeout_o is tied 0.
//
// Ports:
//   clock_i, reset_i        : clock (rising edge), async active-low reset
//   enable_i                : 1 = drain receiver, 0 = idle / config writable
//   cfg_write_i, cfg_*_i    : configuration write strobe and values
//   clock_divider_o,
//   parity_bit_o,
//   parity_even_o           : configuration to the receiver
//   rx_data_i, rx_ready_i   : byte and ready flag from the receiver
//   rx_clear_ready_o        : one-cycle acknowledge to the receiver
//   data_o, valid_o, ready_i: consumer stream (head byte, non-empty, accept)
//   level_o                 : FIFO occupancy 0..DEPTH
//   overrun_o, overrun_clear_i : sticky drop flag and its clear
//   timeout_o               : idle timeout
// -----------------------------------------------------------------------------
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int               DEPTH          = 4,
  parameter logic [DIV_W-1:0] RESET_DIVIDER  = 16'd2,
  parameter int               TIMEOUT_CYCLES = 64
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     cfg_write_i,
  input  logic [DIV_W-1:0]         cfg_divider_i,
  input  logic                     cfg_parity_bit_i,
  input  logic                     cfg_parity_even_i,
  output logic [DIV_W-1:0]         clock_divider_o,
  output logic                     parity_bit_o,
  output logic                     parity_even_o,
  input  logic [DATA_W-1:0]        rx_data_i,
  input  logic                     rx_ready_i,
  output logic                     rx_clear_ready_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overrun_o,
  input  logic                     overrun_clear_i,
  output logic                     timeout_o
);

  rx_state_t r_state;
  rx_state_t w_next_state;

  logic w_take;      // byte offered by receiver is consumed this cycle
  logic w_cfg_we;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_empty;

  logic [DIV_W-1:0] r_divider;
  logic             r_parity_bit;
  logic             r_parity_even;
  logic             r_overrun;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Once a byte is taken the handshake always completes,
  // even if enable_i drops, and WAIT_LOW blocks re-capture of the same byte.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and a latch cannot be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (enable_i && rx_ready_i) w_next_state = CLEAR;
      CLEAR:    w_next_state = WAIT_LOW;
      WAIT_LOW: if (!rx_ready_i)            w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_clear_ready_o = 1'b0;
    w_take           = 1'b0;
    w_cfg_we         = 1'b0;
    case (r_state)
      IDLE: begin
        w_take   = enable_i & rx_ready_i;
        w_cfg_we = ~enable_i & cfg_write_i;
      end
      CLEAR:   rx_clear_ready_o = 1'b1;
      default: ;
    endcase
  end

  // A same-cycle pop frees a slot before the push is judged.
  assign w_pop  = valid_o & ready_i;
  assign w_push = w_take & (~w_full | w_pop);
  assign w_drop = w_take & w_full & ~w_pop;

  // ---------------------------------------------------------------------------
  // Configuration and overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_divider     <= RESET_DIVIDER;
      r_parity_bit  <= 1'b0;
      r_parity_even <= 1'b0;
    end else if (w_cfg_we) begin
      r_divider     <= cfg_divider_i;
      r_parity_bit  <= cfg_parity_bit_i;
      r_parity_even <= cfg_parity_even_i;
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)             r_overrun <= 1'b0;
    else if (w_drop)          r_overrun <= 1'b1;
    else if (overrun_clear_i) r_overrun <= 1'b0;
  end

  assign clock_divider_o = r_divider;
  assign parity_bit_o    = r_parity_bit;
  assign parity_even_o   = r_parity_even;
  assign overrun_o       = r_overrun;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clock_i),
    .rst_n (reset_i),
    .push  (w_push),
    .wdata (rx_data_i),
    .pop   (w_pop),
    .rdata (data_o),
    .full  (w_full),
    .empty (w_empty),
    .level (level_o)
  );

  assign valid_o = ~w_empty;

  // ---------------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------------
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_to_cnt <= '0;
    end else if (w_push || w_pop) begin
      r_to_cnt <= '0;
    end else if (valid_o && (r_to_cnt != TW'(TIMEOUT_CYCLES))) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout_o = (r_to_cnt == TW'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_o        = 1'b0;
`endif

endmodule : uart_rx_controller
